// File: rtl/fetch_stage.sv
// fetch_stage: PC plus single-outstanding imem fetch into a stall-aware decode register; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage #(
  parameter int ARCH_LEN = 32,
  parameter int INST_LEN = 32,
  parameter logic [ARCH_LEN-1:0] BOOT_ADDR = '0,
  parameter logic [INST_LEN-1:0] NOP_INST = INST_LEN'(32'h0000_0013)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ARCH_LEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  input  logic                stall_dec_in,
  input  logic                redirect_valid_in,
  input  logic [ARCH_LEN-1:0] redirect_pc_in,
  output logic [INST_LEN-1:0] inst_fetched_out,
  output logic                inst_valid_out,
  output logic [ARCH_LEN-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched_out,
  output logic [31:0]         perf_stall_out
`endif
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;
  state_t state, state_n;
  logic [ARCH_LEN-1:0] pc, pc_n, req_pc, req_pc_n, out_pc, hold_pc, ld_pc;
  logic [INST_LEN-1:0] out_inst, hold_inst, ld_inst;
  logic out_valid, out_valid_n, ld, hold_we, free;
  assign imem_req_valid = state == REQ;
  assign imem_req_addr = pc;
  assign inst_valid_out = out_valid;
  assign inst_fetched_out = out_valid ? out_inst : NOP_INST;
  assign pc_out = out_pc;
  assign free = ~out_valid | ~stall_dec_in;
  always_comb begin
    state_n = state;
    pc_n = pc;
    req_pc_n = req_pc;
    ld = 1'b0;
    ld_inst = imem_rsp_data;
    ld_pc = req_pc;
    hold_we = 1'b0;
    case (state)
      REQ: if (imem_req_ready) begin
        req_pc_n = pc;
        pc_n = pc + ARCH_LEN'(4);
        state_n = WAIT;
      end
      WAIT: if (imem_rsp_valid) begin
        ld = free;
        hold_we = ~free;
        state_n = free ? REQ : HOLD;
      end
      HOLD: if (!stall_dec_in) begin
        ld = 1'b1;
        ld_inst = hold_inst;
        ld_pc = hold_pc;
        state_n = REQ;
      end
      DRAIN: state_n = imem_rsp_valid ? REQ : DRAIN;
      default: state_n = REQ;
    endcase
    // a squashed request still in flight must have its response swallowed in DRAIN
    if (redirect_valid_in) begin
      pc_n = redirect_pc_in & ~ARCH_LEN'(3);
      ld = 1'b0;
      hold_we = 1'b0;
      state_n = ((state == REQ) & imem_req_ready) | (((state == WAIT) | (state == DRAIN)) & ~imem_rsp_valid) ? DRAIN : REQ;
    end
    out_valid_n = ~redirect_valid_in & (ld | (out_valid & stall_dec_in));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= REQ;
      pc <= BOOT_ADDR;
      req_pc <= BOOT_ADDR;
      out_inst <= NOP_INST;
      out_pc <= BOOT_ADDR;
      out_valid <= 1'b0;
      hold_inst <= NOP_INST;
      hold_pc <= BOOT_ADDR;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_pc <= req_pc_n;
      out_valid <= out_valid_n;
      if (ld) begin
        out_inst <= ld_inst;
        out_pc <= ld_pc;
      end
      if (hold_we) begin
        hold_inst <= imem_rsp_data;
        hold_pc <= req_pc;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_out <= '0;
      perf_stall_out <= '0;
    end else begin
      perf_fetched_out <= perf_fetched_out + 32'(ld);
      perf_stall_out <= perf_stall_out + 32'((state == HOLD) | (stall_dec_in & out_valid));
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a latency-configurable memory model
module tb_fetch_stage;
  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, stall_dec_in, redirect_valid_in, inst_valid_out;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc_in, inst_fetched_out, pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_out, perf_stall_out;
`endif
  int total = 0;
  int bad = 0;
  logic [63:0] q[$];
  logic ready_en, pend, squash;
  int lat, cnt;
  logic [31:0] paddr, exp_pc, special, base;
  fetch_stage #(.BOOT_ADDR(BOOT), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_dec_in(stall_dec_in), .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched_out(perf_fetched_out), .perf_stall_out(perf_stall_out),
`endif
    .inst_fetched_out(inst_fetched_out), .inst_valid_out(inst_valid_out), .pc_out(pc_out)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == special) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic [63:0] e;
    @(negedge clk);
    stall_dec_in = st;
    redirect_valid_in = rd;
    redirect_pc_in = rpc;
    if (rd) q.delete();
    else if (inst_valid_out && !st) begin
      if (q.size() == 0) chk("sb_empty", 32'(inst_valid_out), 0);
      else begin
        e = q.pop_front();
        chk("sb_pc", pc_out, e[63:32]);
        chk("sb_inst", inst_fetched_out, e[31:0]);
      end
    end
    if (!inst_valid_out) chk("nop", inst_fetched_out, NOP);
    imem_rsp_valid = 1'b0;
    imem_req_ready = ready_en;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mem_word(paddr);
        pend = 1'b0;
        if (!squash && !rd) q.push_back({paddr, mem_word(paddr)});
      end else if (rd) squash = 1'b1;
    end
    if (imem_req_valid && ready_en) begin
      chk("req_addr", imem_req_addr, exp_pc);
      pend = 1'b1;
      cnt = lat;
      paddr = exp_pc;
      squash = rd;
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) exp_pc = rpc & ~32'd3;
  endtask
  task automatic drain();
    int i;
    ready_en = 1'b0;
    for (i = 0; i < 30; i++) begin
      step(0, 0, 0);
      if (!pend && !imem_rsp_valid && !inst_valid_out) break;
    end
    chk("drain_bound", 32'(i < 30), 1);
    chk("drain_q", q.size(), 0);
  endtask
  initial begin
    int nv;
    logic pv;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    stall_dec_in = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_pc_in = '0;
    ready_en = 1'b0;
    pend = 1'b0;
    squash = 1'b0;
    lat = 1;
    cnt = 0;
    paddr = '0;
    exp_pc = BOOT;
    special = 32'hFFFF_FFFF;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(inst_valid_out), 0);
    chk("rst_inst", inst_fetched_out, NOP);
    chk("rst_pc", pc_out, BOOT);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_f", perf_fetched_out, 0);
    chk("rst_perf_s", perf_stall_out, 0);
`endif
    rst = 1'b1;
    chk("boot_req_valid", 32'(imem_req_valid), 1);
    chk("boot_req_addr", imem_req_addr, BOOT);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      chk("nrdy_valid", 32'(imem_req_valid), 1);
      chk("nrdy_addr", imem_req_addr, BOOT);
      chk("nrdy_out", 32'(inst_valid_out), 0);
    end
    ready_en = 1'b1;
    nv = 0;
    pv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      chk("t1_gap", 32'(inst_valid_out & pv), 0);
      if (inst_valid_out) nv++;
      pv = inst_valid_out;
    end
    chk("t1_count", nv, 3);
    drain();
    ready_en = 1'b1;
    base = exp_pc;
    special = base + 32'd4;
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("stall_valid", 32'(inst_valid_out), 1);
      chk("stall_pc", pc_out, base);
      chk("stall_inst", inst_fetched_out, mem_word(base));
      if (i >= 2) chk("hold_noreq", 32'(imem_req_valid), 0);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    chk("hold_inst", inst_fetched_out, 32'hDEADBEEF);
    chk("hold_pc", pc_out, special);
    drain();
    ready_en = 1'b1;
    lat = 3;
    step(0, 0, 0);
    step(0, 1, 32'h100);
    step(0, 0, 0);
    chk("rd_valid", 32'(inst_valid_out), 0);
    chk("rd_drain_noreq", 32'(imem_req_valid), 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rd_req_valid", 32'(imem_req_valid), 1);
    chk("rd_req_addr", imem_req_addr, 32'h100);
    drain();
    ready_en = 1'b1;
    lat = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("rs_pre_valid", 32'(inst_valid_out), 1);
    step(1, 1, 32'h203);
    step(0, 0, 0);
    chk("rs_valid", 32'(inst_valid_out), 0);
    chk("rs_req_valid", 32'(imem_req_valid), 1);
    chk("rs_req_addr", imem_req_addr, 32'h200);
    drain();
    ready_en = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("mr_pre_valid", 32'(inst_valid_out), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("mr_valid", 32'(inst_valid_out), 0);
    chk("mr_inst", inst_fetched_out, NOP);
    chk("mr_pc", pc_out, BOOT);
    chk("mr_req_addr", imem_req_addr, BOOT);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_perf_f", perf_fetched_out, 0);
    chk("mr_perf_s", perf_stall_out, 0);
`endif
    pend = 1'b0;
    q.delete();
    exp_pc = BOOT;
    imem_rsp_valid = 1'b0;
    stall_dec_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0);
    chk("mr_boot_addr", imem_req_addr, BOOT);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
